arith4_driver: RTL and testbench
================================

# arith4_driver

Sequencing initiator for the 8-bit four-function arithmetic core. On a start request it walks a built-in operand table, presents every operand pair under each of the four select codes, and holds each combination for a programmable number of cycles. On the final cycle of each hold it samples the core's result and republishes it with a one-cycle valid strobe and a step index. It sits on the driving side of the core's `i_d_a/i_d_b/i_sel -> o_out` interface and lets the core run on the board without an external stimulus source.

## Interface
- `N_PAIRS`, default 3: number of operand-table entries used (1..4).
- `HOLD_CYCLES`, default 4: cycles each step is held (2..255).
- `i_clk`  in  1  rising-edge clock.
- `i_rstn`  in  1  synchronous, active-low reset. Single clock domain; reset is synchronous, active-low.
- `i_start`  in  1  start request, sampled while not busy.
- `i_out`  in  8  result from the core; combinational from `o_d_a/o_d_b/o_sel`.
- `o_d_a`  out  8  operand A to the core.
- `o_d_b`  out  8  operand B to the core.
- `o_sel`  out  2  operation select to the core.
- `o_res`  out  8  captured result.
- `o_res_valid`  out  1  one-cycle strobe; `o_res` and `o_res_idx` are valid.
- `o_res_idx`  out  4  step index of the capture, `{pair[1:0], sel[1:0]}`.
- `o_busy`  out  1  high while sequencing.
- `o_done`  out  1  level; the sequence completed and no new start has been accepted.
- `o_err`  out  1  sticky mismatch flag; exists only with `ARITH4_DRV_CHECK_EN`, otherwise tied 0.

## Operation
- Operand table (fixed ROM):
  - entry 0: (2, 1)
  - entry 1: (15, 15)
  - entry 2: (100, 97)
  - entry 3: (255, 1)
- Step order: pair-major, sel-minor, i.e. (p0,s0) (p0,s1) (p0,s2) (p0,s3) (p1,s0) … Total steps = 4·`N_PAIRS`.
- FSM states:
  - IDLE: `o_busy`=0.
  - DRIVE: `o_busy`=1.
  - DONE: `o_busy`=0, `o_done`=1.
- FSM transitions:
  - IDLE or DONE, with `i_start`=1 → DRIVE. Step counter cleared, hold counter cleared, `o_done` cleared, `o_err` cleared.
  - DRIVE, hold counter = `HOLD_CYCLES`−1 and not last step → next step; hold counter cleared.
  - DRIVE, hold counter = `HOLD_CYCLES`−1 and last step → DONE.
- `i_start` is ignored while in DRIVE.
- `o_d_a`, `o_d_b` and `o_sel` are registered. They change only at step boundaries and are stable for exactly `HOLD_CYCLES` cycles per step.
- Capture: on the final hold cycle of a step, register `i_out` into `o_res` and the step index into `o_res_idx`, and set `o_res_valid`=1 for the next cycle only.
- In IDLE and DONE, `o_d_a`, `o_d_b` and `o_sel` keep the last driven values.
- Synchronous reset at any point, including mid-sequence, forces reset values on the next edge. No partial result is emitted.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - counters 0
- `i_start` high at edge k: `o_busy`=1 and step-0 operands appear after edge k. A capture occurs on the last cycle of each step; its `o_res_valid` coincides with the first cycle of the following step.
- Final step: `o_res_valid` and `o_done` rise in the same cycle, and `o_busy` falls in that cycle.
- Total busy time = 4·`N_PAIRS`·`HOLD_CYCLES` cycles. Defaults give 48.
- `i_start` held high continuously: the sequence restarts on the cycle after DONE is entered, and `o_done` is high for one cycle.
- Index wrap: none. The step counter stops at its final value.

## Configuration
- `ARITH4_DRV_CHECK_EN` defined: a golden model compares `i_out` with the expected value at each capture. Expected values by `sel`:
  - 0: (a+b) mod 256
  - 1: (a−b) mod 256
  - 2: (a·b)[7:0]
  - 3: a/b truncated, with b=0 giving 8'hFF
- Any mismatch sets `o_err`. `o_err` stays set until reset or the next accepted start.
- `ARITH4_DRV_CHECK_EN` not defined: no checker logic is built and `o_err` is constant 0.

## Test plan
- Reset held for 3 cycles, then released with `i_start`=0 → all outputs 0, `o_busy`=0 indefinitely.
- Defaults, connected to the core, `i_start` pulsed once → 12 strobes with results 3,1,2,2, 30,0,225,1, 197,3,228,1 at `o_res_idx` 0..11. Strobes are 4 cycles apart. `o_done` rises 48 cycles after start.
- `N_PAIRS`=4, `HOLD_CYCLES`=2 → entry 3 gives 0,254,255,255. Busy for 32 cycles.
- `i_start` pulsed again while busy → no effect. Step order and count are unchanged.
- Reset asserted at step 5 → outputs return to 0 on the next edge with no `o_res_valid`. A new start begins again at step 0.
- With `ARITH4_DRV_CHECK_EN`, a core stub forcing `i_out`=0 → `o_err`=1 from the first capture (expected 3) and it stays set. A subsequent start with the real core clears it, and it stays 0.

Source files
------------

// File: rtl/arith4_driver.sv
// arith4_driver: sequencing initiator for the 8-bit four-function arithmetic core.
// It walks a fixed operand table and drives every pair under all four select codes.
// Each combination is held for HOLD_CYCLES cycles. The core result is captured on the
// last hold cycle and republished with a one-cycle valid strobe and a step index.
// Optional feature macro: ARITH4_DRV_CHECK_EN builds a golden-model checker that
// drives the sticky o_err flag. Without the macro, o_err is tied to 0.
module arith4_driver #(
    parameter int N_PAIRS     = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic [7:0] i_out,
    output logic [7:0] o_d_a,
    output logic [7:0] o_d_b,
    output logic [1:0] o_sel,
    output logic [7:0] o_res,
    output logic       o_res_valid,
    output logic [3:0] o_res_idx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [3:0] LAST_STEP = 4'(4 * N_PAIRS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] step_q;
    logic [7:0] hold_q;
    logic [3:0] step_d;
    logic [7:0] d_a_q, d_b_q, res_q;
    logic [1:0] sel_q;
    logic [3:0] idx_q;
    logic       valid_q, busy_q, done_q;
    logic       capture_d;

    // Operand ROM, indexed by pair number.
    function automatic logic [7:0] rom_a(input logic [1:0] p);
        case (p)
            2'd0:    rom_a = 8'd2;
            2'd1:    rom_a = 8'd15;
            2'd2:    rom_a = 8'd100;
            default: rom_a = 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] rom_b(input logic [1:0] p);
        case (p)
            2'd0:    rom_b = 8'd1;
            2'd1:    rom_b = 8'd15;
            2'd2:    rom_b = 8'd97;
            default: rom_b = 8'd1;
        endcase
    endfunction

    // Next step number and the capture condition (last hold cycle of a step).
    always_comb begin
        step_d    = step_q + 4'd1;
        capture_d = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
    end

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            hold_q  <= 8'd0;
            d_a_q   <= 8'd0;
            d_b_q   <= 8'd0;
            sel_q   <= 2'd0;
            res_q   <= 8'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_q <= S_DRIVE;
                        step_q  <= 4'd0;
                        hold_q  <= 8'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        d_a_q   <= rom_a(2'd0);
                        d_b_q   <= rom_b(2'd0);
                        sel_q   <= 2'd0;
                    end
                end
                S_DRIVE: begin
                    if (capture_d) begin
                        res_q   <= i_out;
                        idx_q   <= step_q;
                        valid_q <= 1'b1;
                        if (step_q == LAST_STEP) begin
                            // Step counter and operands stay at their final values.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= step_d;
                            hold_q <= 8'd0;
                            d_a_q  <= rom_a(step_d[3:2]);
                            d_b_q  <= rom_b(step_d[3:2]);
                            sel_q  <= step_d[1:0];
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_d_a       = d_a_q;
    assign o_d_b       = d_b_q;
    assign o_sel       = sel_q;
    assign o_res       = res_q;
    assign o_res_valid = valid_q;
    assign o_res_idx   = idx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef ARITH4_DRV_CHECK_EN
    logic [15:0] prod_d;
    logic [7:0]  exp_d;
    logic        err_q;

    // Golden model of the core, evaluated on the operands currently driven.
    always_comb begin
        prod_d = d_a_q * d_b_q;
        case (sel_q)
            2'd0:    exp_d = d_a_q + d_b_q;
            2'd1:    exp_d = d_a_q - d_b_q;
            2'd2:    exp_d = prod_d[7:0];
            default: exp_d = (d_b_q == 8'd0) ? 8'hFF : d_a_q / d_b_q;
        endcase
    end

    // Sticky mismatch flag, cleared by reset or an accepted start.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err_q <= 1'b0;
        end else if ((state_q != S_DRIVE) && i_start) begin
            err_q <= 1'b0;
        end else if (capture_d && (i_out != exp_d)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_arith4_driver.sv
// tb_arith4_driver: directed bench for arith4_driver. It uses two instances: the
// defaults (3 pairs, hold 4) and 4 pairs with hold 2. Each instance is connected to
// a behavioural model of the arithmetic core.
module tb_arith4_driver;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start0 = 1'b0;
    logic start4 = 1'b0;
    logic stub_zero = 1'b0;

    logic [7:0] a0, b0, res0, out0, a4, b4, res4, out4;
    logic [1:0] sel0, sel4;
    logic [3:0] idx0, idx4;
    logic       valid0, busy0, done0, err0, valid4, busy4, done4, err4;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Sampled view of the instance under test
    logic [7:0] s_a, s_b, s_res;
    logic [1:0] s_sel;
    logic [3:0] s_idx;
    logic       s_valid, s_busy, s_done, s_err;

    logic [7:0] exp_tab [16];

    // Behavioural arithmetic core
    function automatic logic [7:0] core_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] sel);
        logic [15:0] p;
        p = a * b;
        case (sel)
            2'd0:    core_f = a + b;
            2'd1:    core_f = a - b;
            2'd2:    core_f = p[7:0];
            default: core_f = (b == 8'd0) ? 8'hFF : a / b;
        endcase
    endfunction

    assign out0 = stub_zero ? 8'd0 : core_f(a0, b0, sel0);
    assign out4 = core_f(a4, b4, sel4);

    arith4_driver dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start0), .i_out(out0),
        .o_d_a(a0), .o_d_b(b0), .o_sel(sel0), .o_res(res0), .o_res_valid(valid0),
        .o_res_idx(idx0), .o_busy(busy0), .o_done(done0), .o_err(err0)
    );

    arith4_driver #(.N_PAIRS(4), .HOLD_CYCLES(2)) dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start4), .i_out(out4),
        .o_d_a(a4), .o_d_b(b4), .o_sel(sel4), .o_res(res4), .o_res_valid(valid4),
        .o_res_idx(idx4), .o_busy(busy4), .o_done(done4), .o_err(err4)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic sample(input int which);
        if (which == 1) begin
            s_a = a4; s_b = b4; s_sel = sel4; s_res = res4; s_idx = idx4;
            s_valid = valid4; s_busy = busy4; s_done = done4; s_err = err4;
        end else begin
            s_a = a0; s_b = b0; s_sel = sel0; s_res = res0; s_idx = idx0;
            s_valid = valid0; s_busy = busy0; s_done = done0; s_err = err0;
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 1) start4 = v;
        else start0 = v;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({a0, b0, sel0, res0, valid0, idx0, busy0, done0, err0} !== 36'd0) begin
                $display("FAIL reset_dut0 cycle %0d: got %h required 0", i,
                         {a0, b0, sel0, res0, valid0, idx0, busy0, done0, err0});
            end else pass_cnt++;
            total_cnt++;
            if ({a4, b4, sel4, res4, valid4, idx4, busy4, done4, err4} !== 36'd0) begin
                $display("FAIL reset_dut4 cycle %0d: got %h required 0", i,
                         {a4, b4, sel4, res4, valid4, idx4, busy4, done4, err4});
            end else pass_cnt++;
        end
    endtask

    // One full sequence with the real core. Optionally pokes i_start mid-run.
    task automatic run_seq(input int which, input bit poke);
        int nsteps, hold, c, n, busy_cycles, done_c;
        nsteps = (which == 1) ? 16 : 12;
        hold   = (which == 1) ? 2 : 4;
        n = 0; busy_cycles = 0; done_c = -1;
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        c = 1;
        sample(which);
        total_cnt++;
        if ({s_busy, s_a, s_b, s_sel} !== {1'b1, 8'd2, 8'd1, 2'd0}) begin
            $display("FAIL start_step0 dut%0d: got busy=%0d a=%0d b=%0d sel=%0d required 1/2/1/0",
                     which, s_busy, s_a, s_b, s_sel);
        end else pass_cnt++;
        while (c < 200) begin
            if (s_busy) busy_cycles++;
            if (s_valid) begin
                total_cnt++;
                if (n >= nsteps || s_res !== exp_tab[n] || s_idx !== 4'(n)
                    || c != 1 + hold * (n + 1)) begin
                    $display("FAIL strobe%0d dut%0d: got res=%0d idx=%0d cycle=%0d required res=%0d idx=%0d cycle=%0d",
                             n, which, s_res, s_idx, c, exp_tab[n % 16], n, 1 + hold * (n + 1));
                end else pass_cnt++;
                n++;
            end
            if (s_done) begin
                done_c = c;
                break;
            end
            if (poke && (c == 10 || c == 20)) set_start(which, 1'b1);
            else set_start(which, 1'b0);
            @(negedge clk);
            c++;
            sample(which);
        end
        set_start(which, 1'b0);
        total_cnt++;
        if (done_c != 1 + hold * nsteps) begin
            $display("FAIL done_cycle dut%0d: got %0d required %0d", which, done_c, 1 + hold * nsteps);
        end else pass_cnt++;
        total_cnt++;
        if (n != nsteps || busy_cycles != hold * nsteps) begin
            $display("FAIL counts dut%0d: got strobes=%0d busy=%0d required %0d/%0d",
                     which, n, busy_cycles, nsteps, hold * nsteps);
        end else pass_cnt++;
        total_cnt++;
        if (s_err !== 1'b0) begin
            $display("FAIL err_clean dut%0d: got %0d required 0", which, s_err);
        end else pass_cnt++;
        // Operands hold their last value in DONE
        @(negedge clk);
        sample(which);
        total_cnt++;
        if ({s_busy, s_done, s_valid, s_a, s_b, s_sel} !==
            {1'b0, 1'b1, 1'b0, (which == 1) ? 8'd255 : 8'd100, (which == 1) ? 8'd1 : 8'd97, 2'd3}) begin
            $display("FAIL done_hold dut%0d: got busy=%0d done=%0d valid=%0d a=%0d b=%0d sel=%0d",
                     which, s_busy, s_done, s_valid, s_a, s_b, s_sel);
        end else pass_cnt++;
    endtask

    task automatic test_sequence();
        run_seq(0, 1'b0);
    endtask

    task automatic test_pairs4();
        run_seq(1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_seq(0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int c;
        c = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        // Strobe for step 4 marks the first cycle of step 5
        while (c < 100 && !(valid0 && idx0 == 4'd4)) begin
            @(negedge clk);
            c++;
        end
        total_cnt++;
        if (c >= 100) $display("FAIL reach_step5: timeout after %0d cycles", c);
        else pass_cnt++;
        rstn = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({a0, b0, sel0, res0, valid0, idx0, busy0, done0, err0} !== 36'd0) begin
            $display("FAIL reset_mid: got %h required 0",
                     {a0, b0, sel0, res0, valid0, idx0, busy0, done0, err0});
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (valid0 !== 1'b0) $display("FAIL reset_mid_valid: got %0d required 0", valid0);
        else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
        run_seq(0, 1'b0);
    endtask

    task automatic test_continuous_start();
        int c, done_cnt;
        c = 0; done_cnt = 0;
        start0 = 1'b1;
        @(negedge clk);
        while (c < 200 && !done0) begin
            @(negedge clk);
            c++;
        end
        total_cnt++;
        if (!done0) $display("FAIL cont_done: timeout after %0d cycles", c);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done0, busy0, a0, b0, sel0} !== {1'b0, 1'b1, 8'd2, 8'd1, 2'd0}) begin
            $display("FAIL cont_restart: got done=%0d busy=%0d a=%0d b=%0d sel=%0d required 0/1/2/1/0",
                     done0, busy0, a0, b0, sel0);
        end else pass_cnt++;
        start0 = 1'b0;
        c = 0;
        while (c < 200 && !done0) begin
            @(negedge clk);
            c++;
        end
        total_cnt++;
        if (!done0) $display("FAIL cont_finish: timeout after %0d cycles", c);
        else pass_cnt++;
    endtask

`ifdef ARITH4_DRV_CHECK_EN
    task automatic test_err();
        int c;
        stub_zero = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        c = 1;
        total_cnt++;
        if (err0 !== 1'b0) $display("FAIL err_before_capture: got %0d required 0", err0);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (err0 !== 1'b1 || valid0 !== 1'b1) begin
            $display("FAIL err_first_capture: got err=%0d valid=%0d required 1/1", err0, valid0);
        end else pass_cnt++;
        c = 5;
        while (c < 200 && !done0) begin
            @(negedge clk);
            c++;
        end
        total_cnt++;
        if (err0 !== 1'b1 || !done0) begin
            $display("FAIL err_sticky: got err=%0d done=%0d required 1/1", err0, done0);
        end else pass_cnt++;
        stub_zero = 1'b0;
        run_seq(0, 1'b0);
    endtask
`endif

    initial begin
        exp_tab = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd30, 8'd0, 8'd225, 8'd1,
                    8'd197, 8'd3, 8'd228, 8'd1, 8'd0, 8'd254, 8'd255, 8'd255};
        @(negedge clk);
        test_reset();
        test_sequence();
        test_pairs4();
        test_start_while_busy();
        test_reset_mid();
        test_continuous_start();
`ifdef ARITH4_DRV_CHECK_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
